// File: rtl/isqrt_residual_checker.sv
// Residual checker for a reciprocal-square-root datapath: R = x*y*y via sequential
// shift-add, pass when |R-1| <= tol. Statistics counters built only with ISQRT_CHECK_STATS_EN.
module isqrt_residual_checker #(
  parameter int WL  = 24,
  parameter int WLO = 24,
  parameter int CW  = 16
) (
  input  logic           CLK,
  input  logic           nRST,
  input  logic           CE,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [WL-1:0]  x,
  input  logic [WLO-1:0] y,
  input  logic [WLO:0]   tol,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [WLO:0]   residual,
  output logic [WLO:0]   err_abs,
  output logic           pass,
  output logic [CW-1:0]  sample_count,
  output logic [CW-1:0]  fail_count
);

  localparam int AW   = WL + WLO;
  localparam int CNTW = $clog2(WLO + 1);
  localparam logic [WLO:0] HALF = {2'b01, {(WLO-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, SQR, MUL, CMP, DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d, mcand_q, mcand_d;
  logic [WLO-1:0]  mplr_q, mplr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [WL-1:0]   x_q, x_d;
  logic [WLO:0]    tol_q, tol_d, res_q, res_d, err_q, err_d;
  logic            pass_q, pass_d;
  logic            step;
  logic [WLO:0]    r_w;

  assign in_ready  = (state_q == IDLE) && CE && nRST;
  assign out_valid = (state_q == DONE);
  assign residual  = res_q;
  assign err_abs   = err_q;
  assign pass      = pass_q;
  assign r_w       = acc_q[WL-1 +: WLO+1];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    tol_d   = tol_q;
    res_d   = res_q;
    err_d   = err_q;
    pass_d  = pass_q;
    step    = 1'b0;
    case (state_q)
      IDLE: if (in_valid && in_ready) begin
        x_d     = x;
        tol_d   = tol;
        acc_d   = '0;
        mcand_d = AW'(y);
        mplr_d  = y;
        cnt_d   = CNTW'(WLO);
        state_d = SQR;
      end
      // The extra SQR edge at cnt==0 truncates y*y and reloads for x*SQ.
      SQR: if (cnt_q != '0) begin
        step = 1'b1;
      end else begin
        mcand_d = AW'(x_q);
        mplr_d  = acc_q[WLO-1 +: WLO];
        acc_d   = '0;
        cnt_d   = CNTW'(WLO);
        state_d = MUL;
      end
      MUL: begin
        step = 1'b1;
        if (cnt_q == CNTW'(1)) state_d = CMP;
      end
      CMP: begin
        res_d   = r_w;
        err_d   = (r_w >= HALF) ? (r_w - HALF) : (HALF - r_w);
        pass_d  = (err_d <= tol_q);
        state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (step) begin
      if (mplr_q[0]) acc_d = acc_q + mcand_q;
      mcand_d = mcand_q << 1;
      mplr_d  = mplr_q >> 1;
      cnt_d   = cnt_q - CNTW'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      tol_q   <= '0;
      res_q   <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
    end else if (CE) begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      tol_q   <= tol_d;
      res_q   <= res_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

`ifdef ISQRT_CHECK_STATS_EN
  logic [CW-1:0] samp_q, fail_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      samp_q <= '0;
      fail_q <= '0;
    end else if (CE && state_q == CMP) begin
      if (samp_q != '1) samp_q <= samp_q + CW'(1);
      if (!pass_d && fail_q != '1) fail_q <= fail_q + CW'(1);
    end
  end

  assign sample_count = samp_q;
  assign fail_count   = fail_q;
`else
  assign sample_count = '0;
  assign fail_count   = '0;
`endif

endmodule

// File: tb/tb_isqrt_residual_checker.sv
// Table-driven, scoreboarded bench for isqrt_residual_checker (WL=WLO=24, CW=4).
module tb_isqrt_residual_checker;

  localparam int WL  = 24;
  localparam int WLO = 24;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic           CLK = 1'b0;
  logic           nRST, CE, in_valid, in_ready, out_valid, out_ready, pass;
  logic [WL-1:0]  x;
  logic [WLO-1:0] y;
  logic [WLO:0]   tol, residual, err_abs;
  logic [CW-1:0]  sample_count, fail_count;

  always #5 CLK = ~CLK;

  isqrt_residual_checker #(.WL(WL), .WLO(WLO), .CW(CW)) dut (
    .CLK(CLK), .nRST(nRST), .CE(CE), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .tol(tol), .out_valid(out_valid), .out_ready(out_ready),
    .residual(residual), .err_abs(err_abs), .pass(pass),
    .sample_count(sample_count), .fail_count(fail_count)
  );

  typedef struct {
    logic [23:0] x;
    logic [23:0] y;
    logic [24:0] tol;
    logic [24:0] res;
    logic [24:0] err;
    logic        pass;
  } vec_t;

  typedef struct {
    logic [24:0] res;
    logic [24:0] err;
    logic        pass;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   n_pass = 0, n_total = 0;
  int   exp_samp = 0, exp_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  // Reference: 64-bit product with truncating bit selects.
  function automatic vec_t mkvec(input logic [23:0] vx, input logic [23:0] vy, input logic [24:0] vt);
    vec_t v;
    logic [63:0] p;
    logic [23:0] sq;
    logic [24:0] half;
    half = 25'h0800000;
    p = 64'(vy) * 64'(vy);
    sq = p[46:23];
    p = 64'(vx) * 64'(sq);
    v.x = vx; v.y = vy; v.tol = vt;
    v.res = p[47:23];
    v.err = (v.res >= half) ? v.res - half : half - v.res;
    v.pass = (v.err <= vt);
    return v;
  endfunction

  function automatic logic [63:0] cnt_exp(input int v);
`ifdef ISQRT_CHECK_STATS_EN
    return 64'(v);
`else
    return 64'(v - v);
`endif
  endfunction

  task automatic run_txn(input vec_t v, input int ce_at, input int ce_len, input int stall);
    exp_t e;
    int lat;
    bit got;
    @(negedge CLK);
    x = v.x; y = v.y; tol = v.tol; in_valid = 1'b1;
    for (int k = 0; k < 20 && !in_ready; k++) @(negedge CLK);
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge CLK);
    e.res = v.res; e.err = v.err; e.pass = v.pass;
    sb.push_back(e);
    #1;
    in_valid = 1'b0;
    x = WL'($urandom); y = WLO'($urandom); tol = (WLO+1)'($urandom);
    lat = 0; got = 0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(posedge CLK); lat++; #1;
      if (out_valid) got = 1;
      else if (lat == ce_at) CE = 1'b0;
      else if (ce_at >= 0 && lat == ce_at + 1) chk("in_ready_ce_low", 64'(in_ready), 64'd0);
      if (ce_at >= 0 && lat == ce_at + ce_len) CE = 1'b1;
    end
    CE = 1'b1;
    if (!got) begin
      chk("out_valid_timeout", 64'(out_valid), 64'd1);
      return;
    end
    chk("latency", 64'(lat), 64'(50 + ce_len));
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    if (exp_samp < SAT) exp_samp++;
    if (!e.pass && exp_fail < SAT) exp_fail++;
    chk("residual", 64'(residual), 64'(e.res));
    chk("err_abs", 64'(err_abs), 64'(e.err));
    chk("pass", 64'(pass), 64'(e.pass));
    chk("sample_count", 64'(sample_count), cnt_exp(exp_samp));
    chk("fail_count", 64'(fail_count), cnt_exp(exp_fail));
    for (int k = 0; k < stall; k++) begin
      @(negedge CLK);
      chk("stall_hold", {out_valid, in_ready, pass, residual, err_abs},
          {1'b1, 1'b0, e.pass, e.res, e.err});
    end
    @(negedge CLK); out_ready = 1'b1;
    @(posedge CLK); #1; out_ready = 1'b0;
    chk("handshake_out_valid", 64'(out_valid), 64'd0);
    chk("handshake_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    vecs[0] = '{24'h800000, 24'h800000, 25'h0000000, 25'h0800000, 25'h0000000, 1'b1};
    vecs[1] = '{24'h800000, 24'h7FFFFF, 25'h0000001, 25'h07FFFFE, 25'h0000002, 1'b0};
    vecs[2] = '{24'h800000, 24'h7FFFFF, 25'h0000002, 25'h07FFFFE, 25'h0000002, 1'b1};
    vecs[3] = '{24'h800000, 24'h400000, 25'h00000FF, 25'h0200000, 25'h0600000, 1'b0};
    vecs[4] = mkvec(24'hC00000, 24'h688000, 25'h0001000);
    vecs[5] = mkvec(24'hFFFFFF, 24'h5A827A, 25'h0000100);
    vecs[6] = mkvec(24'hA00000, 24'h727C97, 25'h0000040);

    nRST = 1'b0; CE = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; tol = '0;
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_outputs", {out_valid, pass, residual, err_abs, sample_count, fail_count}, 64'd0);
    @(negedge CLK); nRST = 1'b1;
    @(negedge CLK);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    CE = 1'b0; #1;
    chk("idle_ce_low_in_ready", 64'(in_ready), 64'd0);
    CE = 1'b1;

    // Abort mid-SQR: result discarded, nothing counted.
    @(negedge CLK);
    x = vecs[0].x; y = vecs[0].y; tol = vecs[0].tol; in_valid = 1'b1;
    @(posedge CLK);
    sb.push_back('{vecs[0].res, vecs[0].err, vecs[0].pass});
    #1; in_valid = 1'b0;
    repeat (10) @(posedge CLK);
    #2; nRST = 1'b0; #1;
    chk("abort_outputs", {out_valid, in_ready, pass, residual, err_abs}, 64'd0);
    chk("abort_sample_count", 64'(sample_count), 64'd0);
    void'(sb.pop_back());
    @(negedge CLK); nRST = 1'b1;
    @(negedge CLK);
    chk("abort_idle_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 7; i++) run_txn(vecs[i], -1, 0, 0);
    run_txn(vecs[3], -1, 0, 10);
    run_txn(vecs[1], 30, 7, 0);

    @(negedge CLK); nRST = 1'b0;
    exp_samp = 0; exp_fail = 0;
    @(negedge CLK); nRST = 1'b1;
    for (int i = 0; i < 20; i++) run_txn(vecs[0], -1, 0, 0);
    chk("sat_sample_count", 64'(sample_count), cnt_exp(SAT));
    chk("sat_fail_count", 64'(fail_count), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/isqrt_residual_checker.md
# isqrt_residual_checker

Hardware self-check unit that sits downstream of the reciprocal-square-root datapath. It consumes each operand/result pair (x, y ≈ 1/√x) and computes the residual R = x·y² with a sequential shift-add multiplier. It flags whether |R − 1| lies within a programmable tolerance. It is the result-side consumer used for on-chip BIST and long-run soak checks, where no MATLAB vectors are available.

## Interface
Parameters:
- WL, 24, input operand word length; x format Q1.(WL-1), values in [1,2)
- WLO, 24, result word length; y format Q1.(WLO-1)
- CW, 16, statistics counter width

Ports:
- CLK  input  1  clock; all state changes on rising edge
- nRST  input  1  asynchronous, active-low reset
- CE  input  1  clock enable; when low, all registers hold
- in_valid  input  1  x/y/tol pair presented
- in_ready  output  1  high only in IDLE with CE=1
- x  input  WL  operand fed to the isqrt datapath
- y  input  WLO  isqrt result under test
- tol  input  WLO+1  allowed |R−1| in Q2.(WLO-1) LSBs; captured with x/y
- out_valid  output  1  check result available
- out_ready  input  1  downstream accepts result
- residual  output  WLO+1  R, Q2.(WLO-1)
- err_abs  output  WLO+1  |R − 2^(WLO-1)| in LSBs
- pass  output  1  err_abs ≤ captured tol
- sample_count  output  CW  checks completed (saturating)
- fail_count  output  CW  checks with pass=0 (saturating)

## Operation
- FSM states: IDLE, SQR, MUL, CMP, DONE.
- IDLE: in_valid && in_ready at an edge captures x, y, tol, clears the accumulator, loads the bit counter with WLO, and moves to SQR.
- SQR: radix-2 shift-add computes y·y, one multiplier bit per enabled edge, LSB first. After WLO edges, SQ = (y·y) >> (WLO-1) is truncated to WLO bits, Q1.(WLO-1). The block then reloads the counter and moves to MUL.
- MUL: shift-add computes x·SQ, with SQ as multiplier, one bit per edge. After WLO edges, R = (x·SQ) >> (WL-1) is truncated to WLO+1 bits. The block then moves to CMP.
- CMP: the block computes err_abs = |R − 2^(WLO-1)|, registers residual, err_abs and pass, updates the counters, and moves to DONE.
- DONE: out_valid=1, and outputs stay stable until out_valid && out_ready at an edge, which returns the block to IDLE.
- Arithmetic: all intermediates are unsigned and truncated, never rounded. R < 2 always fits WLO+1 bits. The accumulator width is WL+WLO.
- One transaction in flight at a time; there is no overlap and no input buffering.
- Counters saturate at 2^CW−1 and never wrap.

## Timing
- Reset values: in_ready=0 while nRST=0, and 1 in IDLE afterwards. out_valid=0, residual=0, err_abs=0, pass=0, sample_count=0, fail_count=0. State is IDLE.
- Latency: with the capture edge as edge 0 and CE held high, out_valid rises after edge 2·WLO+2, which is 50 cycles at WLO=24.
- CE low freezes the state, counters, accumulator and outputs. Each CE-low cycle adds exactly one cycle of latency. in_ready is 0 while CE=0.
- in_ready is 0 in every state except IDLE. in_valid in other states is ignored, and x/y/tol changes after capture have no effect.
- out_valid && out_ready at an edge puts the block in IDLE, so in_ready=1 in the next cycle. The earliest back-to-back accept is one cycle after the handshake.
- out_ready while out_valid=0 has no effect.
- Asserting nRST mid-transaction immediately forces IDLE and all reset values. The partial result is discarded and not counted.

## Configuration
- ISQRT_CHECK_STATS_EN defined: the sample_count and fail_count registers and their increment logic are compiled in.
- Not defined: no counter registers are built, and sample_count and fail_count are driven constant 0. All other behaviour and the latency are unchanged.

## Test plan
- x=24'h800000, y=24'h800000, tol=0 -> residual=25'h0800000, err_abs=0, pass=1, out_valid exactly 50 cycles after capture.
- x=24'h800000, y=24'h7FFFFF, tol=1 -> SQ=24'h7FFFFE, residual=25'h07FFFFE, err_abs=2, pass=0. Repeat with tol=2 -> pass=1.
- x=24'h800000, y=24'h400000, tol=25'h0000FF -> residual=25'h0200000, err_abs=25'h0600000, pass=0, fail_count increments by 1.
- Hold out_ready=0 for 10 cycles after out_valid -> outputs and out_valid stable, in_ready=0. Raise out_ready -> in_ready=1 the next cycle.
- Drop CE for 7 cycles during MUL -> out_valid after 57 cycles with a result identical to the uninterrupted run. Drop nRST mid-SQR -> all outputs 0, state IDLE, sample_count unchanged.
- With ISQRT_CHECK_STATS_EN, CW=4: 20 passing checks -> sample_count=15 (saturated), fail_count=0. Without the macro, both counters read 0.
